// File: rtl/mips_pkg.sv
// mips_pkg: datapath-wide widths and the hardwired-zero register index.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the register file with integrated scoreboard.
interface regfile_sb_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W
);
  logic rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic rd_valid;
  logic hazard;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic iss_en;
  logic [ADDR_W-1:0] iss_addr;
  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input rd_data1, rd_data2, rd_valid, hazard
  );
  modport slave (
    input rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data1, rd_data2, rd_valid, hazard
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: busy bit per register, set on issue, cleared on writeback.
module reg_scoreboard #(
  parameter int DEPTH = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic pend1,
  output logic pend2
);
  logic [DEPTH-1:0] busy, busyNext;
  // issue is applied after the clear so a same-cycle new producer wins
  always_comb begin
    busyNext = busy;
    if (wr_en) busyNext[wr_addr] = 1'b0;
    if (iss_en && !(ZERO_REG && iss_addr == '0)) busyNext[iss_addr] = 1'b1;
  end
  always_ff @(posedge clock)
    busy <= reset ? '0 : busyNext;
  function automatic logic pend(input logic [ADDR_W-1:0] a);
    return busy[a] && !(wr_en && wr_addr == a) && !(ZERO_REG && a == '0);
  endfunction
  assign pend1 = pend(addr1);
  assign pend2 = pend(addr2);
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with registered reads, write bypass and hazard scoreboard.
module regfile_sb #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int DEPTH = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input logic clock,
  input logic reset,
  regfile_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] src1, src2;
  logic pend1, pend2, accept, wrOk;
  reg_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) scoreboard (
    .clock(clock),
    .reset(reset),
    .iss_en(bus.iss_en),
    .iss_addr(bus.iss_addr),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr),
    .addr1(bus.rd_addr1),
    .addr2(bus.rd_addr2),
    .pend1(pend1),
    .pend2(pend2)
  );
  assign bus.hazard = bus.rd_en & (pend1 | pend2);
  assign accept = bus.rd_en & ~bus.hazard;
  assign wrOk = bus.wr_en && !(ZERO_REG && bus.wr_addr == '0);
  always_comb begin
    src1 = (ZERO_REG && bus.rd_addr1 == '0) ? '0
         : (BYPASS && bus.wr_en && bus.wr_addr == bus.rd_addr1) ? bus.wr_data : mem[bus.rd_addr1];
    src2 = (ZERO_REG && bus.rd_addr2 == '0) ? '0
         : (BYPASS && bus.wr_en && bus.wr_addr == bus.rd_addr2) ? bus.wr_data : mem[bus.rd_addr2];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.rd_data1 <= '0;
      bus.rd_data2 <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (wrOk) mem[bus.wr_addr] <= bus.wr_data;
      bus.rd_valid <= accept;
      if (accept) begin
        bus.rd_data1 <= src1;
        bus.rd_data2 <= src2;
      end
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors; expected reads queued at issue, checked by a monitor on rd_valid.
module tb_regfile_sb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_sb #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;

  logic [63:0] expQ [$];
  int checks = 0, errors = 0, monChecks = 0, monErrors = 0;

  always @(negedge clock) begin
    if (!reset && bus.rd_valid) begin
      monChecks++;
      if (expQ.size() == 0) begin
        monErrors++;
        $display("FAIL unexpected_rd_valid: got data1=%h data2=%h, required no valid output", bus.rd_data1, bus.rd_data2);
      end else begin
        logic [63:0] e;
        e = expQ.pop_front();
        if ({bus.rd_data1, bus.rd_data2} !== e) begin
          monErrors++;
          $display("FAIL read_data: got %h/%h, required %h/%h", bus.rd_data1, bus.rd_data2, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_en = 1'b1;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    bus.iss_en = 1'b1;
    bus.iss_addr = a;
  endtask

  task automatic step(input logic expHz, input logic [31:0] e1, input logic [31:0] e2);
    #1;
    if (bus.rd_en) begin
      chk("hazard", {31'd0, bus.hazard}, {31'd0, expHz});
      if (!expHz) expQ.push_back({e1, e2});
    end
    @(posedge clock);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.iss_en = 1'b0;
  endtask

  initial begin
    bus.rd_en = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("reset_data1", bus.rd_data1, 32'd0);
    chk("reset_data2", bus.rd_data2, 32'd0);
    rd(5, 31); step(1'b0, 32'h0, 32'h0);
    wr(7, 32'hDEADBEEF); rd(7, 0); step(1'b0, 32'hDEADBEEF, 32'h0);
    rd(7, 7); step(1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    wr(0, 32'h1234); step(1'b0, 32'h0, 32'h0);
    rd(0, 7); step(1'b0, 32'h0, 32'hDEADBEEF);
    iss(0); step(1'b0, 32'h0, 32'h0);
    rd(0, 0); step(1'b0, 32'h0, 32'h0);
    rd(7, 0); step(1'b0, 32'hDEADBEEF, 32'h0);
    iss(3); step(1'b0, 32'h0, 32'h0);
    rd(3, 5); step(1'b1, 32'h0, 32'h0);
    chk("stall_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("stall_hold1", bus.rd_data1, 32'hDEADBEEF);
    chk("stall_hold2", bus.rd_data2, 32'h0);
    rd(5, 3); step(1'b1, 32'h0, 32'h0);
    wr(3, 32'h55); rd(3, 7); step(1'b0, 32'h55, 32'hDEADBEEF);
    iss(9); wr(9, 32'h1); step(1'b0, 32'h0, 32'h0);
    bus.rd_addr1 = 5'd9;
    #1 chk("hazard_no_rd_en", {31'd0, bus.hazard}, 32'd0);
    rd(9, 0); step(1'b1, 32'h0, 32'h0);
    rd(0, 9); step(1'b1, 32'h0, 32'h0);
    wr(9, 32'h77); rd(9, 9); step(1'b0, 32'h77, 32'h77);
    rd(9, 3); step(1'b0, 32'h77, 32'h55);
    iss(4); step(1'b0, 32'h0, 32'h0);
    reset = 1'b1; rd(4, 4); step(1'b1, 32'h0, 32'h0);
    reset = 1'b0;
    chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_data1", bus.rd_data1, 32'd0);
    chk("rst_data2", bus.rd_data2, 32'd0);
    rd(4, 7); step(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1 chk("queue_drained", expQ.size(), 32'd0);
    checks += monChecks;
    errors += monErrors;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
